// File: rtl/mm_tile_scheduler.sv
// rtl/mm_tile_scheduler.sv - tile loop sequencer for the matrix-multiply accelerator
module mm_tile_scheduler #(
  parameter int SIZE   = 16,
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_start,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_addr_a,
  input  logic [ADDR_W-1:0] cfg_addr_b,
  input  logic [ADDR_W-1:0] cfg_addr_c,
  output logic              busy,
  output logic              done,
  output logic              ld_valid,
  input  logic              ld_ready,
  output logic              ld_sel,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DIM_W-1:0]  ld_stride,
  output logic [DIM_W-1:0]  ld_rows,
  output logic [DIM_W-1:0]  ld_cols,
  input  logic              ld_done,
  output logic              cmp_start,
  output logic              cmp_acc_clr,
  input  logic              cmp_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DIM_W-1:0]  wb_rows,
  output logic [DIM_W-1:0]  wb_cols,
  input  logic              wb_done
);

  localparam int              LG      = $clog2(SIZE);
  localparam logic [DIM_W:0]  SIZE_X  = (DIM_W+1)'(SIZE);
  localparam logic [ADDR_W-1:0] AB_NSTEP = ADDR_W'(SIZE);
  localparam logic [ADDR_W-1:0] C_NSTEP  = ADDR_W'(SIZE) << 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_WB, S_DONE
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  k_q, n_q, kt;
  // Remaining extents from the current tile origin; one extra bit so they never underflow.
  logic [DIM_W:0]    m_rem, k_rem, n_rem;
  // Row-start and current-tile pointers, advanced by adders only.
  logic [ADDR_W-1:0] base_b, a_row, a_ptr, b_col, b_ptr, c_row, c_ptr;
  logic [ADDR_W-1:0] a_mstep, b_kstep, c_mstep;
  logic [DIM_W-1:0]  m_ext, k_ext, n_ext;
  logic              last_k, last_n, last_m, zero_dim;

  function automatic logic [DIM_W-1:0] clip(input logic [DIM_W:0] rem);
    return (rem > SIZE_X) ? SIZE_X[DIM_W-1:0] : rem[DIM_W-1:0];
  endfunction

  assign m_ext    = clip(m_rem);
  assign k_ext    = clip(k_rem);
  assign n_ext    = clip(n_rem);
  assign last_k   = (k_rem <= SIZE_X);
  assign last_n   = (n_rem <= SIZE_X);
  assign last_m   = (m_rem <= SIZE_X);
  assign zero_dim = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);

  // Payload is taken straight from registered pointers, so it is stable while a request waits.
  assign ld_addr   = ld_sel ? b_ptr : a_ptr;
  assign ld_stride = ld_sel ? n_q   : k_q;
  assign ld_rows   = ld_sel ? k_ext : m_ext;
  assign ld_cols   = ld_sel ? n_ext : k_ext;
  assign wb_addr   = c_ptr;
  assign wb_rows   = m_ext;
  assign wb_cols   = n_ext;

  // Job sequencer: state, handshakes, tile counters and pointer updates.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ld_valid    <= 1'b0;
      ld_sel      <= 1'b0;
      cmp_start   <= 1'b0;
      cmp_acc_clr <= 1'b0;
      wb_valid    <= 1'b0;
      k_q         <= '0;
      n_q         <= '0;
      kt          <= '0;
      m_rem       <= '0;
      k_rem       <= '0;
      n_rem       <= '0;
      base_b      <= '0;
      a_row       <= '0;
      a_ptr       <= '0;
      b_col       <= '0;
      b_ptr       <= '0;
      c_row       <= '0;
      c_ptr       <= '0;
      a_mstep     <= '0;
      b_kstep     <= '0;
      c_mstep     <= '0;
    end else begin
      done        <= 1'b0;
      cmp_start   <= 1'b0;
      cmp_acc_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            k_q     <= cfg_k;
            n_q     <= cfg_n;
            kt      <= '0;
            m_rem   <= {1'b0, cfg_m};
            k_rem   <= {1'b0, cfg_k};
            n_rem   <= {1'b0, cfg_n};
            base_b  <= cfg_addr_b;
            a_row   <= cfg_addr_a;
            a_ptr   <= cfg_addr_a;
            b_col   <= cfg_addr_b;
            b_ptr   <= cfg_addr_b;
            c_row   <= cfg_addr_c;
            c_ptr   <= cfg_addr_c;
            a_mstep <= ADDR_W'(cfg_k) << LG;
            b_kstep <= ADDR_W'(cfg_n) << LG;
            c_mstep <= ADDR_W'(cfg_n) << (LG + 2);
            if (zero_dim) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_LOAD_A;
              busy     <= 1'b1;
              ld_valid <= 1'b1;
              ld_sel   <= 1'b0;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          // Acceptance wins over a same-cycle ld_done; ld_done only counts once accepted.
          if (ld_valid) begin
            if (ld_ready) ld_valid <= 1'b0;
          end else if (ld_done) begin
            if (state == S_LOAD_A) begin
              state    <= S_LOAD_B;
              ld_valid <= 1'b1;
              ld_sel   <= 1'b1;
            end else begin
              state       <= S_COMPUTE;
              ld_sel      <= 1'b0;
              cmp_start   <= 1'b1;
              cmp_acc_clr <= (kt == '0);
            end
          end
        end
        S_COMPUTE: begin
          if (cmp_done && !cmp_start) begin
            if (!last_k) begin
              kt       <= kt + DIM_W'(1);
              k_rem    <= k_rem - SIZE_X;
              a_ptr    <= a_ptr + AB_NSTEP;
              b_ptr    <= b_ptr + b_kstep;
              state    <= S_LOAD_A;
              ld_valid <= 1'b1;
              ld_sel   <= 1'b0;
            end else begin
              state    <= S_WB;
              wb_valid <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (wb_valid) begin
            if (wb_ready) wb_valid <= 1'b0;
          end else if (wb_done) begin
            kt    <= '0;
            k_rem <= {1'b0, k_q};
            if (!last_n) begin
              n_rem    <= n_rem - SIZE_X;
              b_col    <= b_col + AB_NSTEP;
              b_ptr    <= b_col + AB_NSTEP;
              a_ptr    <= a_row;
              c_ptr    <= c_ptr + C_NSTEP;
              state    <= S_LOAD_A;
              ld_valid <= 1'b1;
            end else begin
              n_rem <= {1'b0, n_q};
              b_col <= base_b;
              b_ptr <= base_b;
              if (last_m) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                m_rem    <= m_rem - SIZE_X;
                a_row    <= a_row + a_mstep;
                a_ptr    <= a_row + a_mstep;
                c_row    <= c_row + c_mstep;
                c_ptr    <= c_row + c_mstep;
                state    <= S_LOAD_A;
                ld_valid <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mm_tile_scheduler.md
# mm_tile_scheduler

Top-level sequencer for the matrix-multiply accelerator. It latches one C = A×B job of size m×k × k×n and walks the output in SIZE×SIZE tiles. For each tile it requests the A and B tile loads from the DMA/buffer loader, pulses the systolic array for each k-slice, and requests the C writeback. It sits between the CSR front end and the loader, array and writeback engines, and owns all tile loop counters and address generation.

## Interface
- SIZE, 16, array edge and tile edge in elements.
- DIM_W, 16, width of m/k/n.
- ADDR_W, 32, byte address width.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- cfg_start  in  1  job start pulse; ignored while busy.
- cfg_m, cfg_k, cfg_n  in  DIM_W each  matrix dimensions.
- cfg_addr_a, cfg_addr_b, cfg_addr_c  in  ADDR_W each  row-major base addresses. A and B use 1 byte/element, C uses 4 bytes/element.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- ld_valid  out  1  load request valid.
- ld_ready  in  1  loader accepts the request.
- ld_sel  out  1  0 = A tile, 1 = B tile.
- ld_addr  out  ADDR_W  tile origin byte address.
- ld_stride  out  DIM_W  row stride in bytes (k for A, n for B).
- ld_rows, ld_cols  out  DIM_W each  valid extent, 1..SIZE; the loader zero-pads the remainder.
- ld_done  in  1  pulse: requested tile is resident.
- cmp_start  out  1  one-cycle compute pulse.
- cmp_acc_clr  out  1  qualifies cmp_start; high on the first k-slice.
- cmp_done  in  1  pulse: k-slice accumulated.
- wb_valid  out  1  writeback request valid.
- wb_ready  in  1  writeback engine accepts.
- wb_addr  out  ADDR_W  C tile origin byte address.
- wb_rows, wb_cols  out  DIM_W each  valid C extent.
- wb_done  in  1  pulse: C tile written.

## Operation
- On an accepted cfg_start, all cfg_* values are latched, tile counters mt, nt and kt are cleared, and the block enters LOAD_A.
- If m, k or n is 0, the block goes straight to DONE and issues no requests.
- Loop order: mt outer, nt middle, kt inner. Tile counts are ceil(dim/SIZE).
- LOAD_A: request A tile.
  - ld_addr = base_a + mt·SIZE·k + kt·SIZE.
  - ld_rows = min(SIZE, m−mt·SIZE), ld_cols = min(SIZE, k−kt·SIZE).
  - On ld_done go to LOAD_B.
- LOAD_B: request B tile.
  - ld_addr = base_b + kt·SIZE·n + nt·SIZE.
  - ld_rows = min(SIZE, k−kt·SIZE), ld_cols = min(SIZE, n−nt·SIZE).
  - On ld_done go to COMPUTE.
- COMPUTE: pulse cmp_start once on entry, with cmp_acc_clr = (kt==0). On cmp_done:
  - if kt is not the last slice: kt++ and go to LOAD_A;
  - otherwise go to WRITEBACK.
- WRITEBACK: request C tile.
  - wb_addr = base_c + 4·(mt·SIZE·n + nt·SIZE).
  - Extents = min(SIZE, m−mt·SIZE) × min(SIZE, n−nt·SIZE).
  - On wb_done: kt = 0, then advance nt; when nt wraps, advance mt. If that was the last tile, go to DONE; otherwise go to LOAD_A.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- Addresses are generated with incremental row/column pointer adders, with no multipliers. Arithmetic wraps modulo 2^ADDR_W. Extent subtractions use DIM_W+1 bits, so no underflow occurs.
- ld_done, cmp_done and wb_done arriving in any state other than the one waiting for them are ignored.

## Timing
- Reset values: busy, done, ld_valid, cmp_start, cmp_acc_clr and wb_valid are 0; ld_sel, addresses and extents are 0; state is IDLE.
- A reset asserted mid-job forces these values on the next edge and abandons the job.
- cfg_start sampled at edge T: busy and ld_valid are high from T+1. Zero-dimension case: done pulses at T+1 and busy stays 0.
- Valid/ready rules:
  - ld_valid (and wb_valid) stays high with all payload stable until the first edge at which ld_ready (wb_ready) is high.
  - ld_valid drops the cycle after acceptance and is never re-raised before the matching done.
  - ld_valid is never asserted without being in LOAD_A/LOAD_B.
- ld_ready and ld_done in the same cycle: acceptance is taken; ld_done is ignored unless the request was already accepted.
- State transitions take 1 cycle after ld_done, cmp_done or wb_done. The next request's valid is asserted in the cycle of state entry.
- cmp_start is exactly one cycle, in the first COMPUTE cycle.
- A cfg_start pulse arriving in the same cycle as done is ignored.

## Test plan
- m=k=n=16, bases A=0x1000, B=0x2000, C=0x3000, loader/array/writeback each responding after 3 cycles:
  - requests in order: A@0x1000 (16×16), B@0x2000 (16×16), one cmp_start with acc_clr=1, wb@0x3000 (16×16);
  - then a single done pulse; busy for the whole span.
- m=20, k=40, n=16:
  - 2×1 output tiles with 3 k-slices each;
  - A addresses 0x1000/0x1010/0x1020, then 0x1280/0x1290/0x12A0;
  - last A extents 4×8; acc_clr only on kt=0;
  - wb addresses 0x3000 and 0x3400, with wb_rows 16 then 4.
- ld_ready held low for 10 cycles: ld_valid, ld_addr and ld_rows/ld_cols stay constant; no state advance; exactly one request accepted.
- cfg_n=0: done at T+1, and no ld_valid, cmp_start or wb_valid ever asserted. A second cfg_start while busy is ignored, with no counter reset.
- rstn low for 1 cycle during COMPUTE of tile (1,0):
  - all outputs are 0 the next cycle and the block is idle;
  - a fresh start then begins at A base with mt=nt=kt=0.
- Spurious cmp_done during LOAD_A and a stray wb_done during COMPUTE: no state change, and the request sequence is identical to the first test.
